kernel_loader: RTL and testbench

Serial-to-parallel weight loader that sits directly upstream of the kernel pruning stage in the CNN accelerator. It accepts 8-bit signed kernel weights one per cycle from the RISC-V side over a valid/ready stream and assembles them into a 3×3 kernel. It presents the kernel as nine registered weights `ker10`…`ker32` with a valid/ready handshake toward the pruning/convolution datapath. A fill buffer plus an output register let the next kernel load while the current one is held.

---
 rtl/kload_pkg.sv | 24 ++
 rtl/kernel_loader.sv | 129 ++++++++++++
 tb/tb_kernel_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/kload_pkg.sv
// Shared constants and state type for the 3x3 kernel weight loader.
package kload_pkg;

  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int IDX_W  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } kload_state_t;

  // Row-major positions inside the fill/output buffers.
  localparam int K10 = 0;
  localparam int K11 = 1;
  localparam int K12 = 2;
  localparam int K20 = 3;
  localparam int K21 = 4;
  localparam int K22 = 5;
  localparam int K30 = 6;
  localparam int K31 = 7;
  localparam int K32 = 8;

endpackage

// File: rtl/kernel_loader.sv
// Serial-to-parallel 3x3 weight loader with fill buffer and output register.
// Optional zero-weight count on zero_cnt when KLOAD_ZCNT_EN is defined.
//
// state | meaning
// FILL  | accepting weights into fbuf (w_ready=1)
// HOLD  | fbuf holds a complete kernel, obuf still occupied (w_ready=0)
module kernel_loader
  import kload_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  input  logic              w_last,
  output logic              w_ready,
  output logic [DATA_W-1:0] ker10,
  output logic [DATA_W-1:0] ker11,
  output logic [DATA_W-1:0] ker12,
  output logic [DATA_W-1:0] ker20,
  output logic [DATA_W-1:0] ker21,
  output logic [DATA_W-1:0] ker22,
  output logic [DATA_W-1:0] ker30,
  output logic [DATA_W-1:0] ker31,
  output logic [DATA_W-1:0] ker32,
  output logic              k_valid,
  input  logic              k_ready,
  output logic              err_len,
  input  logic              err_clr
`ifdef KLOAD_ZCNT_EN
  ,
  output logic [3:0]        zero_cnt
`endif
);

  kload_state_t      state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] fbuf [TAPS];
  logic [DATA_W-1:0] obuf [TAPS];

  logic accept, idx_last, complete, err_set, load_direct, load_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    w_ready     = (state == FILL);
    accept      = w_valid & (state == FILL);
    idx_last    = (idx == IDX_W'(TAPS - 1));
    complete    = accept & idx_last & w_last;
    err_set     = accept & (idx_last ^ w_last);
    load_direct = complete & (~k_valid | k_ready);
    load_hold   = (state == HOLD) & k_ready;
    case (state)
      FILL: if (complete && !load_direct) state_nxt = HOLD;
      HOLD: if (k_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      k_valid <= 1'b0;
      err_len <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        fbuf[i] <= '0;
        obuf[i] <= '0;
      end
    end else begin
      if (accept) fbuf[idx] <= w_data;

      if (err_set || load_direct || load_hold) idx <= '0;
      else if (accept && !idx_last)           idx <= idx + 1'b1;

      // The 9th word bypasses fbuf so a direct load costs no extra cycle.
      if (load_direct) begin
        for (int i = 0; i < TAPS - 1; i++) obuf[i] <= fbuf[i];
        obuf[TAPS-1] <= w_data;
      end else if (load_hold) begin
        for (int i = 0; i < TAPS; i++) obuf[i] <= fbuf[i];
      end

      if (load_direct || load_hold) k_valid <= 1'b1;
      else if (k_ready)             k_valid <= 1'b0;

      if (err_set)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
    end
  end

`ifdef KLOAD_ZCNT_EN
  logic [3:0] zacc, zacc_nxt;

  assign zacc_nxt = zacc + {3'b000, (w_data == '0)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zacc     <= '0;
      zero_cnt <= '0;
    end else begin
      if (load_direct) begin
        zero_cnt <= zacc_nxt;
        zacc     <= '0;
      end else if (load_hold) begin
        zero_cnt <= zacc;
        zacc     <= '0;
      end else if (err_set) begin
        zacc     <= '0;
      end else if (accept) begin
        zacc     <= zacc_nxt;
      end
    end
  end
`endif

  assign ker10 = obuf[K10];
  assign ker11 = obuf[K11];
  assign ker12 = obuf[K12];
  assign ker20 = obuf[K20];
  assign ker21 = obuf[K21];
  assign ker22 = obuf[K22];
  assign ker30 = obuf[K30];
  assign ker31 = obuf[K31];
  assign ker32 = obuf[K32];

endmodule

// File: tb/tb_kernel_loader.sv
// Directed self-checking bench for kernel_loader (zero-count checks only with KLOAD_ZCNT_EN).
module tb_kernel_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] w_data;
  logic       w_valid, w_last, w_ready;
  logic [7:0] ker10, ker11, ker12, ker20, ker21, ker22, ker30, ker31, ker32;
  logic       k_valid, k_ready, err_len, err_clr;
`ifdef KLOAD_ZCNT_EN
  logic [3:0] zero_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] kv [9];
  logic [7:0] exp_k [9];

  always #5 clk = ~clk;

  kernel_loader dut (
    .clk(clk), .rst(rst),
    .w_data(w_data), .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready),
    .ker10(ker10), .ker11(ker11), .ker12(ker12),
    .ker20(ker20), .ker21(ker21), .ker22(ker22),
    .ker30(ker30), .ker31(ker31), .ker32(ker32),
    .k_valid(k_valid), .k_ready(k_ready),
    .err_len(err_len), .err_clr(err_clr)
`ifdef KLOAD_ZCNT_EN
    , .zero_cnt(zero_cnt)
`endif
  );

  assign kv[0] = ker10; assign kv[1] = ker11; assign kv[2] = ker12;
  assign kv[3] = ker20; assign kv[4] = ker21; assign kv[5] = ker22;
  assign kv[6] = ker30; assign kv[7] = ker31; assign kv[8] = ker32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_kernel(input string tag);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s ker[%0d]", tag, i), {24'd0, kv[i]}, {24'd0, exp_k[i]});
  endtask

  // Drive one word across one rising edge; returns at the following negedge.
  task automatic push(input logic [7:0] d, input logic last);
    w_valid = 1'b1;
    w_data  = d;
    w_last  = last;
    @(negedge clk);
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  // Pushes base+1 .. base+9 with w_last on the 9th and records the expectation.
  task automatic push_seq(input logic [7:0] base);
    for (int i = 0; i < 9; i++) begin
      exp_k[i] = base + 8'(i + 1);
      push(exp_k[i], i == 8);
    end
  endtask

  initial begin
    logic [7:0] t3 [9];
    t3[0] = 8'hC9; t3[1] = 8'h37; t3[2] = 8'h80; t3[3] = 8'h00; t3[4] = 8'hFF;
    t3[5] = 8'h7F; t3[6] = 8'h01; t3[7] = 8'hFE; t3[8] = 8'h42;

    rst = 1'b1; w_data = '0; w_valid = 1'b0; w_last = 1'b0;
    k_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst k_valid", {31'd0, k_valid}, 0);
    chk("rst err_len", {31'd0, err_len}, 0);
    chk("rst ker10", {24'd0, ker10}, 0);
    chk("rst ker32", {24'd0, ker32}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst w_ready", {31'd0, w_ready}, 1);

    // Basic kernel, consumer always ready
    k_ready = 1'b1;
    push_seq(8'h00);
    chk("t1 k_valid", {31'd0, k_valid}, 1);
    chk_kernel("t1");
    @(negedge clk);
    chk("t1 k_valid drop", {31'd0, k_valid}, 0);
    chk("t1 ker10 retained", {24'd0, ker10}, 8'h01);

    // Back-pressure: A presented, B parks in the fill buffer
    k_ready = 1'b0;
    push_seq(8'h10);
    chk("t2 A k_valid", {31'd0, k_valid}, 1);
    push_seq(8'h20);
    chk("t2 hold w_ready", {31'd0, w_ready}, 0);
    chk("t2 hold ker10", {24'd0, ker10}, 8'h11);
    chk("t2 hold ker32", {24'd0, ker32}, 8'h19);
    @(negedge clk);
    chk("t2 hold w_ready 2", {31'd0, w_ready}, 0);
    k_ready = 1'b1;
    @(negedge clk);
    k_ready = 1'b0;
    chk("t2 B k_valid", {31'd0, k_valid}, 1);
    chk("t2 B w_ready", {31'd0, w_ready}, 1);
    chk_kernel("t2B");
    k_ready = 1'b1;
    @(negedge clk);
    chk("t2 B consumed", {31'd0, k_valid}, 0);

    // Early last on 5th word, then a clean kernel with odd values
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), i == 4);
    chk("t3 err_len", {31'd0, err_len}, 1);
    chk("t3 no k_valid", {31'd0, k_valid}, 0);
    for (int i = 0; i < 9; i++) begin
      exp_k[i] = t3[i];
      push(t3[i], i == 8);
    end
    chk("t3 k_valid", {31'd0, k_valid}, 1);
    chk_kernel("t3");
    chk("t3 err sticky", {31'd0, err_len}, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3 err_clr", {31'd0, err_len}, 0);

    // Missing last: nine words without w_last
    for (int i = 0; i < 9; i++) push(8'h70 + 8'(i), 1'b0);
    chk("t4 err_len", {31'd0, err_len}, 1);
    chk("t4 no k_valid", {31'd0, k_valid}, 0);
    chk("t4 ker10 unchanged", {24'd0, ker10}, 8'hC9);
    push_seq(8'h50);
    chk("t4 realign k_valid", {31'd0, k_valid}, 1);
    chk_kernel("t4");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Reset mid-fill
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 rst k_valid", {31'd0, k_valid}, 0);
    chk("t5 rst ker10", {24'd0, ker10}, 0);
    chk("t5 rst ker22", {24'd0, ker22}, 0);
    chk("t5 rst err_len", {31'd0, err_len}, 0);
    rst = 1'b0;
    @(negedge clk);
    push_seq(8'hA0);
    chk("t5 k_valid", {31'd0, k_valid}, 1);
    chk_kernel("t5");

`ifdef KLOAD_ZCNT_EN
    begin
      logic [7:0] zk [9];
      zk[0] = 8'd0; zk[1] = 8'd5; zk[2] = 8'd0; zk[3] = 8'd7; zk[4] = 8'd0;
      zk[5] = 8'd1; zk[6] = 8'd2; zk[7] = 8'd3; zk[8] = 8'd4;
      for (int i = 0; i < 9; i++) push(zk[i], i == 8);
      chk("t6 k_valid", {31'd0, k_valid}, 1);
      chk("t6 zero_cnt", {28'd0, zero_cnt}, 3);
      // Early-last error must discard its zeros from the running count
      push(8'd0, 1'b0);
      push(8'd0, 1'b1);
      for (int i = 0; i < 9; i++) push((i == 8) ? 8'd0 : 8'd9, i == 8);
      chk("t6 zero_cnt after err", {28'd0, zero_cnt}, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
